// File: rtl/qformat_pkg.sv
// Shared Q-format constants and divider state encoding.
package qformat_pkg;

   localparam int unsigned QDIV_N = 16;
   localparam int unsigned QDIV_Q = 12;

   localparam logic [15:0] QMAX = 16'h7FFF;
   localparam logic [15:0] QMIN = 16'h8000;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDiv,
      StFix,
      StDone
   } state_e;

endpackage

// File: rtl/qdiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module qdiv_step #(
   parameter int unsigned W = 16
) (
   input  logic [W:0]   rem,
   input  logic         in_bit,
   input  logic [W-1:0] divisor,
   output logic [W:0]   rem_next,
   output logic         q_bit
);

   logic [W+1:0] shifted;
   logic [W+1:0] trial;

   always_comb begin
      shifted  = {rem, in_bit};
      trial    = shifted - {2'b00, divisor};
      // No borrow out of the top bit means the divisor fits.
      q_bit    = ~trial[W+1];
      rem_next = q_bit ? trial[W:0] : shifted[W:0];
   end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed Q-format divider, one quotient bit per clock, valid/ready on both sides.
// Define QDIV_ROUND_EN for an extra guard bit and half-away-from-zero rounding.
module qdiv_seq
   import qformat_pkg::*;
#(
   parameter int unsigned N = QDIV_N,
   parameter int unsigned Q = QDIV_Q
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] q_result,
   output logic         overflow,
   output logic         div_by_zero
);

`ifdef QDIV_ROUND_EN
   localparam int unsigned Guard = 1;
`else
   localparam int unsigned Guard = 0;
`endif
   localparam int unsigned Shift = Q + Guard;
   localparam int unsigned Dw    = N + Shift;
   localparam int unsigned Iter  = Dw;
   localparam int unsigned Cw    = $clog2(Iter);

   localparam logic [N-1:0]  SatPos    = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  SatNeg    = {1'b1, {(N-1){1'b0}}};
   localparam logic [Dw-1:0] MagPosMax = Dw'(SatPos);
   localparam logic [Dw-1:0] MagNegMax = Dw'(SatNeg);

   state_e         state_q, state_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d;
   logic [N-1:0]   mag_b_q, mag_b_d;
   logic           sign_q, sign_d, neg_a_q, neg_a_d, dbz_q, dbz_d;
   logic [Dw-1:0]  dvd_q, dvd_d;
   logic [N:0]     rem_q, rem_d, rem_step;
   logic [Cw-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   res_q, res_d;
   logic           ovf_q, ovf_d, dz_q, dz_d, valid_q, valid_d;
   logic           q_bit;
   logic [N-1:0]   mag_a;
   logic [Dw-1:0]  mag_fix;

   // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
   qdiv_step #(
      .W (N)
   ) u_step (
      .rem      (rem_q),
      .in_bit   (dvd_q[Dw-1]),
      .divisor  (mag_b_q),
      .rem_next (rem_step),
      .q_bit    (q_bit)
   );

   always_comb begin
      mag_a = a_q[N-1] ? (N'(0) - a_q) : a_q;
`ifdef QDIV_ROUND_EN
      mag_fix = {1'b0, dvd_q[Dw-1:1]} + Dw'(dvd_q[0]);
`else
      mag_fix = dvd_q;
`endif
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mag_b_d = mag_b_q;
      sign_d  = sign_q;
      neg_a_d = neg_a_q;
      dbz_d   = dbz_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      valid_d = valid_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               state_d = StLoad;
            end
         end
         StLoad: begin
            sign_d  = (a_q[N-1] ^ b_q[N-1]) && (a_q != '0);
            neg_a_d = a_q[N-1];
            mag_b_d = b_q[N-1] ? (N'(0) - b_q) : b_q;
            dvd_d   = {mag_a, {Shift{1'b0}}};
            rem_d   = '0;
            cnt_d   = Cw'(Iter - 1);
            dbz_d   = (b_q == '0);
            state_d = (b_q == '0) ? StFix : StDiv;
         end
         StDiv: begin
            rem_d = rem_step;
            dvd_d = {dvd_q[Dw-2:0], q_bit};
            cnt_d = cnt_q - Cw'(1);
            if (cnt_q == '0) begin
               state_d = StFix;
            end
         end
         StFix: begin
            ovf_d = 1'b0;
            dz_d  = dbz_q;
            if (dbz_q) begin
               res_d = neg_a_q ? SatNeg : SatPos;
            end else if (!sign_q && (mag_fix > MagPosMax)) begin
               res_d = SatPos;
               ovf_d = 1'b1;
            end else if (sign_q && (mag_fix > MagNegMax)) begin
               res_d = SatNeg;
               ovf_d = 1'b1;
            end else begin
               res_d = sign_q ? (N'(0) - mag_fix[N-1:0]) : mag_fix[N-1:0];
            end
            valid_d = 1'b0;
            state_d = StDone;
         end
         StDone: begin
            // Results are registered on entry; out_valid follows one cycle later.
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         mag_b_q <= '0;
         sign_q  <= 1'b0;
         neg_a_q <= 1'b0;
         dbz_q   <= 1'b0;
         dvd_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mag_b_q <= mag_b_d;
         sign_q  <= sign_d;
         neg_a_q <= neg_a_d;
         dbz_q   <= dbz_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = valid_q;
   assign q_result    = res_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed corners plus random operands against an arithmetic model.
module tb_qdiv_seq;
   import qformat_pkg::*;

`ifdef QDIV_ROUND_EN
   localparam int Iter = 29;
`else
   localparam int Iter = 28;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] q_result;
   logic        overflow;
   logic        div_by_zero;

   int n_checks = 0;
   int n_err    = 0;

   qdiv_seq dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .q_result    (q_result),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: real-valued quotient scaled by 2^12, truncated or rounded half away from zero.
   task automatic model(input logic [15:0] ta, input logic [15:0] tb,
                        output logic [15:0] r, output logic ov, output logic dz);
      longint sa, sb, ma, mb, num, mag;
      bit neg;
      sa = longint'($signed(ta));
      sb = longint'($signed(tb));
      ov = 1'b0;
      dz = 1'b0;
      if (sb == 0) begin
         dz = 1'b1;
         r  = (sa >= 0) ? QMAX : QMIN;
         return;
      end
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      num = ma * 4096;
`ifdef QDIV_ROUND_EN
      mag = (2 * num + mb) / (2 * mb);
`else
      mag = num / mb;
`endif
      neg = (sa < 0) != (sb < 0);
      if (!neg && mag > 32767) begin
         r  = QMAX;
         ov = 1'b1;
      end else if (neg && mag > 32768) begin
         r  = QMIN;
         ov = 1'b1;
      end else begin
         r = neg ? 16'(-mag) : 16'(mag);
      end
   endtask

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input int stall);
      logic [15:0] er;
      logic        eov, edz;
      int          n, lat;
      model(ta, tb, er, eov, edz);
      lat = edz ? 3 : Iter + 3;
      @(negedge clk);
      check_eq("in_ready_idle", 32'(in_ready), 32'd1);
      a        = ta;
      b        = tb;
      in_valid = 1'b1;
      @(negedge clk);
      // Junk operands while busy must be ignored.
      a = ~ta;
      b = tb ^ 16'h5A5A;
      n = 0;
      while (!out_valid && n < 200) begin
         if (n == 0) check_eq("in_ready_busy", 32'(in_ready), 32'd0);
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check_eq($sformatf("latency %h/%h", ta, tb), n, lat);
      check_eq($sformatf("q_result %h/%h", ta, tb), 32'(q_result), 32'(er));
      check_eq($sformatf("overflow %h/%h", ta, tb), 32'(overflow), 32'(eov));
      check_eq($sformatf("div_by_zero %h/%h", ta, tb), 32'(div_by_zero), 32'(edz));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_result", 32'(q_result), 32'(er));
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("valid_cleared", 32'(out_valid), 32'd0);
      check_eq("in_ready_after", 32'(in_ready), 32'd1);
   endtask

   logic [15:0] dir_a [12] = '{16'h1800, 16'hE000, 16'h2000, 16'hE000, 16'h7000, 16'h9000,
                               16'h1000, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h8000};
   logic [15:0] dir_b [12] = '{16'h0800, 16'h0800, 16'h3000, 16'h3000, 16'h0400, 16'h0400,
                               16'h0000, 16'h0000, 16'h1000, 16'h8000, 16'h1000, 16'hFFFF};

   initial begin
      int          seen;
      logic [15:0] ra, rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_q_result", 32'(q_result), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         do_op(dir_a[i], dir_b[i], (i == 4) ? 10 : 0);
      end

      // Abort mid-division; the previous result must also be cleared.
      @(negedge clk);
      a        = 16'h1800;
      b        = 16'h0800;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_q_result", 32'(q_result), 32'd0);
      check_eq("abort_overflow", 32'(overflow), 32'd0);
      check_eq("abort_div_by_zero", 32'(div_by_zero), 32'd0);
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      rst  = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_eq("abort_no_valid", seen, 0);
      do_op(16'h1000, 16'h1000, 0);

      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         do_op(ra, rb, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
